// File: rtl/ofm_addr_controller.sv
// OFM RAM write-address controller: accepts drained output words and writes them in tile order.
// Optional ReLU on the write data when OFM_RELU_EN is defined.
module ofm_addr_controller #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned OFM_RAM_SIZE  = 524172,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            valid_in,
  input  logic signed [DATA_WIDTH-1:0]    data_in,
  output logic                            ready_out,
  output logic [$clog2(OFM_RAM_SIZE)-1:0] ofm_addr,
  output logic                            write_en,
  output logic signed [DATA_WIDTH-1:0]    ofm_data,
  output logic                            tile_done,
  output logic                            layer_done,
  input  logic [8:0]                      ofm_size,
  input  logic [17:0]                     channel_size,
  input  logic [10:0]                     ofm_channel
);

  localparam int unsigned AW = $clog2(OFM_RAM_SIZE);
  localparam int unsigned PW = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int unsigned FW = $clog2(SYSTOLIC_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WRITE    = 2'd2,
    TILE_END = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          p_q, p_d;
  logic [FW-1:0]          f_q, f_d;
  logic [AW-1:0]          f_off_q, f_off_d;
  logic [8:0]             row_q, row_d;
  logic [AW-1:0]          row_base_q, row_base_d;
  logic [8:0]             col_base_q, col_base_d;
  logic [AW-1:0]          group_base_q, group_base_d;
  logic [10:0]            group_ch_q, group_ch_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   tile_done_q, tile_done_d;
  logic                   layer_done_q, layer_done_d;

  logic                   xfer_c;
  logic                   last_word_c;
  logic                   row_last_c;
  logic                   col_last_c;
  logic                   grp_last_c;
  logic                   layer_last_c;
  logic                   in_bounds_c;
  logic [AW-1:0]          wr_addr_c;
  logic [DATA_WIDTH-1:0]  wdata_c;

  // Position decode for the current transfer and the tile currently being filled.
  always_comb begin
    xfer_c       = ready_q && valid_in;
    last_word_c  = xfer_c && (p_q == PW'(SYSTOLIC_SIZE - 1)) && (f_q == FW'(SYSTOLIC_SIZE - 1));
    row_last_c   = (row_q == (ofm_size - 9'd1));
    col_last_c   = (32'(col_base_q) + SYSTOLIC_SIZE) >= 32'(ofm_size);
    grp_last_c   = (32'(group_ch_q) + SYSTOLIC_SIZE) >= 32'(ofm_channel);
    layer_last_c = row_last_c && col_last_c && grp_last_c;
    in_bounds_c  = ((32'(col_base_q) + 32'(p_q)) < 32'(ofm_size)) &&
                   ((32'(group_ch_q) + 32'(f_q)) < 32'(ofm_channel));
    wr_addr_c    = group_base_q + row_base_q + AW'(col_base_q) + f_off_q + AW'(p_q);
`ifdef OFM_RELU_EN
    wdata_c      = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    wdata_c      = data_in;
`endif
  end

  // Next-state, traversal counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    f_d          = f_q;
    f_off_d      = f_off_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    col_base_d   = col_base_q;
    group_base_d = group_base_q;
    group_ch_d   = group_ch_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    tile_done_d  = 1'b0;
    layer_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
        end
      end

      ARMED, WRITE: begin
        if (xfer_c) begin
          state_d = WRITE;
          we_d    = in_bounds_c;
          addr_d  = wr_addr_c;
          data_d  = wdata_c;
          // f/f_off run up to S and S*channel_size on the last word; that sum is the group stride.
          if (p_q == PW'(SYSTOLIC_SIZE - 1)) begin
            p_d     = '0;
            f_d     = f_q + FW'(1);
            f_off_d = f_off_q + AW'(channel_size);
          end else begin
            p_d = p_q + PW'(1);
          end
          if (last_word_c) begin
            state_d      = TILE_END;
            tile_done_d  = 1'b1;
            layer_done_d = layer_last_c;
          end
        end else begin
          state_d = ARMED;
        end
      end

      TILE_END: begin
        p_d     = '0;
        f_d     = '0;
        f_off_d = '0;
        state_d = layer_last_c ? IDLE : ARMED;
        if (!row_last_c) begin
          row_d      = row_q + 9'd1;
          row_base_d = row_base_q + AW'(ofm_size);
        end else begin
          row_d      = '0;
          row_base_d = '0;
          if (!col_last_c) begin
            col_base_d = col_base_q + 9'(SYSTOLIC_SIZE);
          end else begin
            col_base_d = '0;
            if (!grp_last_c) begin
              group_base_d = group_base_q + f_off_q;
              group_ch_d   = group_ch_q + 11'(SYSTOLIC_SIZE);
            end else begin
              group_base_d = '0;
              group_ch_d   = '0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == ARMED) || (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= '0;
      f_q          <= '0;
      f_off_q      <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      col_base_q   <= '0;
      group_base_q <= '0;
      group_ch_q   <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      tile_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      f_q          <= f_d;
      f_off_q      <= f_off_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      col_base_q   <= col_base_d;
      group_base_q <= group_base_d;
      group_ch_q   <= group_ch_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      tile_done_q  <= tile_done_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign ready_out  = ready_q;
  assign write_en   = we_q;
  assign ofm_addr   = addr_q;
  assign ofm_data   = data_q;
  assign tile_done  = tile_done_q;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Scoreboard bench for ofm_addr_controller with S=4, 6x6 outputs, 5 filters.
module tb_ofm_addr_controller;

  localparam int S   = 4;
  localparam int OFM = 6;
  localparam int CS  = 36;
  localparam int CH  = 5;
  localparam int AW  = $clog2(524172);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          valid_in;
  logic [15:0]   data_in;
  logic          ready_out;
  logic [AW-1:0] ofm_addr;
  logic          write_en;
  logic [15:0]   ofm_data;
  logic          tile_done;
  logic          layer_done;
  logic [8:0]    ofm_size     = 9'(OFM);
  logic [17:0]   channel_size = 18'(CS);
  logic [10:0]   ofm_channel  = 11'(CH);

  ofm_addr_controller #(.SYSTOLIC_SIZE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .ofm_addr(ofm_addr), .write_en(write_en), .ofm_data(ofm_data),
    .tile_done(tile_done), .layer_done(layer_done), .ofm_size(ofm_size),
    .channel_size(channel_size), .ofm_channel(ofm_channel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    int          addr;
    logic [15:0] data;
    logic        td;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int we_cnt = 0, tile_cnt = 0, layer_cnt = 0;
  int md_p = 0, md_f = 0, md_row = 0, md_col = 0, md_grp = 0;
  int gi = 0;
  logic exp_ready_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [15:0] d);
`ifdef OFM_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [15:0] gen(input int k);
    if (k == 0) return 16'hFFFB;
    if (k == 1) return 16'd9;
    return 16'($urandom);
  endfunction

  // Scoreboard: predict on acceptance, compare one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      md_p = 0; md_f = 0; md_row = 0; md_col = 0; md_grp = 0;
      exp_ready_next = 1'b0;
    end else begin
      if (exp_ready_next) chk("ready_after_tile", 32'(ready_out), 32'd1);
      exp_ready_next = 1'b0;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("write_en", 32'(write_en), 32'(e.we));
        chk("tile_done", 32'(tile_done), 32'(e.td));
        chk("layer_done", 32'(layer_done), 32'(e.ld));
        if (e.we) begin
          chk("ofm_addr", 32'(ofm_addr), 32'(e.addr));
          chk("ofm_data", 32'(ofm_data), 32'(e.data));
        end
        if (e.td) begin
          chk("ready_in_tile_end", 32'(ready_out), 32'd0);
          exp_ready_next = !e.ld;
        end
      end else begin
        chk("spurious_write_en", 32'(write_en), 32'd0);
        chk("spurious_tile_done", 32'(tile_done), 32'd0);
        chk("spurious_layer_done", 32'(layer_done), 32'd0);
      end
      if (write_en) we_cnt++;
      if (tile_done) tile_cnt++;
      if (layer_done) layer_cnt++;

      if (valid_in && ready_out) begin
        exp_t n;
        n.we   = ((md_col + md_p) < OFM) && ((md_grp + md_f) < CH);
        n.addr = (md_grp * CS + md_f * CS + md_row * OFM + md_col + md_p) % (1 << AW);
        n.data = exp_data(data_in);
        n.td   = (md_p == S - 1) && (md_f == S - 1);
        n.ld   = n.td && (md_row == OFM - 1) && (md_col + S >= OFM) && (md_grp + S >= CH);
        sb.push_back(n);
        md_p++;
        if (md_p == S) begin
          md_p = 0;
          md_f++;
          if (md_f == S) begin
            md_f = 0;
            if (md_row < OFM - 1) md_row++;
            else begin
              md_row = 0;
              md_col += S;
              if (md_col >= OFM) begin
                md_col = 0;
                md_grp += S;
                if (md_grp >= CH) md_grp = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input int pct);
    int sent = 0;
    int cyc = 0;
    logic acc;
    data_in = gen(gi);
    while (sent < n && cyc < 4 * n + 50) begin
      valid_in = ($urandom_range(99) < pct);
      acc = valid_in && ready_out;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        gi++;
        data_in = gen(gi);
      end
    end
    valid_in = 1'b0;
    chk("words_accepted", 32'(sent), 32'(n));
  endtask

  initial begin
    int tc;
    int lc;
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b0; data_in = '0;
    repeat (3) tick();
    chk("rst_ofm_addr", 32'(ofm_addr), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_ofm_data", 32'(ofm_data), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    chk("rst_tile_done", 32'(tile_done), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready_out", 32'(ready_out), 32'd0);

    // First tile back-to-back, then continue to the end of the layer.
    pulse_start();
    chk("armed_ready_out", 32'(ready_out), 32'd1);
    send(16, 100);
    repeat (2) tick();
    chk("first_tile_count", 32'(tile_cnt), 32'd1);
    send(80, 100);
    pulse_start();
    send(288, 100);
    repeat (3) tick();
    chk("layer1_tiles", 32'(tile_cnt), 32'd24);
    chk("layer1_layer_done", 32'(layer_cnt), 32'd1);
    chk("layer1_writes", 32'(we_cnt), 32'd180);
    valid_in = 1'b1;
    repeat (4) tick();
    chk("idle_after_layer", 32'(ready_out), 32'd0);
    valid_in = 1'b0;

    // Second layer with randomly gapped valid_in.
    pulse_start();
    send(384, 50);
    repeat (3) tick();
    chk("layer2_tiles", 32'(tile_cnt), 32'd48);
    chk("layer2_layer_done", 32'(layer_cnt), 32'd2);
    chk("layer2_writes", 32'(we_cnt), 32'd360);

    // Reset in the middle of a tile.
    pulse_start();
    send(7, 100);
    tc = tile_cnt;
    lc = layer_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_write_en", 32'(write_en), 32'd0);
    chk("midrst_ofm_addr", 32'(ofm_addr), 32'd0);
    chk("midrst_ofm_data", 32'(ofm_data), 32'd0);
    chk("midrst_ready_out", 32'(ready_out), 32'd0);
    chk("midrst_tile_done", 32'(tile_done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("midrst_no_tile_done", 32'(tile_cnt), 32'(tc));
    pulse_start();
    send(16, 100);
    repeat (3) tick();
    chk("post_rst_tile", 32'(tile_cnt), 32'(tc + 1));
    chk("post_rst_no_layer", 32'(layer_cnt), 32'(lc));
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ofm_addr_controller.md
Name: ofm_addr_controller

Overview:
- Write-side counterpart of the IFM read address generator: accepts output words drained from the systolic array over a valid/ready handshake and writes them into OFM RAM.
- Each transfer produces one registered write address, write enable and data word.
- Tile traversal matches the IFM side: one output row segment of SYSTOLIC_SIZE pixels × SYSTOLIC_SIZE filters per tile, then rows, then column strips, then filter groups.
- Signals tile and layer completion to the top-level controller.

Parameters:
- SYSTOLIC_SIZE, 16, pixels per tile row segment and filters per tile.
- OFM_RAM_SIZE, 524172, OFM RAM depth in words; address width is $clog2(OFM_RAM_SIZE).
- DATA_WIDTH, 16, signed output word width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; arms the block for a new layer.
- valid_in  input  1  drain word available.
- data_in  input  DATA_WIDTH  drain word, signed.
- ready_out  output  1  block can accept a word.
- ofm_addr  output  $clog2(OFM_RAM_SIZE)  OFM RAM write address.
- write_en  output  1  OFM RAM write strobe.
- ofm_data  output  DATA_WIDTH  OFM RAM write data.
- tile_done  output  1  one-cycle pulse at the end of each tile.
- layer_done  output  1  one-cycle pulse at the end of the last tile.
- ofm_size  input  9  output width = height in pixels.
- channel_size  input  18  ofm_size*ofm_size, words per output channel.
- ofm_channel  input  11  number of output channels (filters).

Behaviour:
- Reset: all outputs 0, all counters and address registers 0, state IDLE.
- Config inputs are held stable while state is not IDLE.
- States:
  - IDLE: start -> ARMED.
  - ARMED/WRITE: ready_out=1. A transfer occurs when valid_in && ready_out; state goes WRITE on a transfer, ARMED when idle.
  - TILE_END: one cycle with ready_out=0. Goes to IDLE if the tile was the last of the layer, else ARMED.
- start outside IDLE is ignored.
- Word order within a tile: pixel index p (0..S-1) is the fastest counter, then filter index f (0..S-1). S*S transfers per tile.
- Write address = group_base + f*channel_size + row*ofm_size + col_base + p.
  - Maintained as running sums; no multipliers.
  - Modulo 2^addr_width; no overflow check.
- Write timing: ofm_addr, ofm_data and write_en are registered, one cycle after the transfer; write_en=0 in every cycle without a transfer.
- Boundary suppression: write_en stays 0 for a transfer, but the word is still consumed, when:
  - col_base+p >= ofm_size (partial last column strip), or
  - group_base_ch+f >= ofm_channel (partial last filter group).
- Transfer with p=S-1 and f=S-1 -> TILE_END next cycle. In TILE_END, tile_done=1 and:
  - row < ofm_size-1: row+1.
  - Otherwise row=0 and col_base+=S.
  - If col_base+S >= ofm_size: col_base=0, group_base+=S*channel_size, group_base_ch+=S.
  - If additionally group_base_ch+S >= ofm_channel: layer_done=1 together with tile_done, all traversal registers clear to 0.
- Counters p and f clear on TILE_END.
- valid_in during TILE_END or IDLE is not accepted (ready_out=0); the upstream holds its data.
- Reset mid-tile: immediate return to IDLE with all registers 0; partially written data is discarded, no done pulses.

Optional Feature:
- OFM_RELU_EN defined: ofm_data = 0 when data_in is negative (MSB=1), otherwise data_in; same latency, no extra stage.
- OFM_RELU_EN undefined: ofm_data = data_in unchanged.

Test Plan:
- S=4, ofm_size=6, channel_size=36, ofm_channel=5; start, then 16 back-to-back transfers. Required:
  - write addresses 0,1,2,3,36,37,38,39,72,…,108..111, one per cycle, one cycle after each transfer.
  - tile_done one cycle after the 16th transfer, ready_out low for exactly that cycle.
- Same config, 6 tiles later (col_base=4, row=0). Required: writes only for p=0,1 (addr 4,5; 40,41; …); p=2,3 consumed with write_en=0.
- Full layer, same config. Required:
  - 24 tile_done pulses, layer_done coincident with the 24th only.
  - 384 transfers, exactly 180 write_en cycles; in the second group only f=0 writes, at addresses 144..179.
  - Block returns to IDLE, and a second start reproduces address 0 first.
- valid_in toggled randomly (~50%). Required: addresses and data match the back-to-back run; no write_en without a prior transfer.
- rst_n asserted mid-tile after 7 transfers. Required:
  - outputs 0 immediately; no tile_done.
  - after release, start gives first address 0.
- With OFM_RELU_EN: data_in=-5 -> ofm_data=0; data_in=+9 -> 9. Without it: -5 passes through unchanged.
